adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 171 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: N_REQ requesters share one WIDTH-bit adder through a
// round-robin arbiter; a single result buffer drives a valid/ready response.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   req_valid  per-requester request valid                 [N_REQ]
//   req_a      packed operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      packed operand B, packed the same way
//   req_ready  one-hot grant, combinational                [N_REQ]
//   rsp_valid  result buffer holds a valid sum
//   rsp_ready  consumer accepts the result this cycle
//   rsp_sum    registered A+B mod 2^WIDTH
//   rsp_id     index of the requester that owns rsp_sum   [2]
//   rsp_ovf    registered signed overflow (only with ADDER_ARB_OVF_EN)
//
// Optional feature macro: ADDER_ARB_OVF_EN adds the rsp_ovf output.
module adder_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_REQ = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic [1:0]             rsp_id
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                   rsp_ovf
`endif
);

    // Requester index space is padded to 4 so a 2-bit index never leaves range.
    localparam int unsigned MAX_REQ = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] sum_q;
    logic [1:0]       id_q;

    logic [MAX_REQ-1:0] valid_pad;
    logic [WIDTH-1:0]   a_arr [MAX_REQ];
    logic [WIDTH-1:0]   b_arr [MAX_REQ];

    logic             found;
    logic [1:0]       gnt_idx;
    logic [2:0]       cand;
    logic [2:0]       ptr_inc;
    logic             accept;
    logic             handshake;
    logic [WIDTH-1:0] op_a, op_b, sum_c;

    // Unpack per-requester operands; unused slots read as idle zeros.
    for (genvar i = 0; i < MAX_REQ; i++) begin : g_lane
        if (i < N_REQ) begin : g_used
            assign valid_pad[i] = req_valid[i];
            assign a_arr[i]     = req_a[i*WIDTH +: WIDTH];
            assign b_arr[i]     = req_b[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign valid_pad[i] = 1'b0;
            assign a_arr[i]     = '0;
            assign b_arr[i]     = '0;
        end
    end

    // Round-robin search: first valid requester at or cyclically above rr_ptr.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 3'(rr_ptr_q) + 3'(k);
            if (cand >= 3'(N_REQ)) begin
                cand = cand - 3'(N_REQ);
            end
            if (!found && valid_pad[cand[1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[1:0];
            end
        end
    end

    // Grant is suppressed during reset so nothing is handed off into a flush.
    always_comb begin
        req_ready = '0;
        accept    = (state_q == EMPTY) || rsp_ready;
        handshake = !reset && accept && found;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i] = handshake && (gnt_idx == 2'(i));
        end
    end

    // The single shared adder, fed by the granted requester's operands.
    always_comb begin
        op_a  = a_arr[gnt_idx];
        op_b  = b_arr[gnt_idx];
        sum_c = op_a + op_b;
    end

    // Next state and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        ptr_inc  = '0;
        if (state_q == EMPTY) begin
            if (handshake) begin
                state_d = FULL;
            end
        end else begin
            if (rsp_ready && !handshake) begin
                state_d = EMPTY;
            end
        end
        if (handshake) begin
            ptr_inc = 3'(gnt_idx) + 3'd1;
            if (ptr_inc == 3'(N_REQ)) begin
                ptr_inc = '0;
            end
            rr_ptr_d = ptr_inc[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            sum_q    <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (handshake) begin
                sum_q <= sum_c;
                id_q  <= gnt_idx;
            end
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;

`ifdef ADDER_ARB_OVF_EN
    logic ovf_q;
    logic ovf_c;

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    assign ovf_c = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_c[WIDTH-1] != op_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (handshake) begin
            ovf_q <= ovf_c;
        end
    end

    assign rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a driver computes the expected grant
// and result from a behavioural model and queues the result; a monitor pops
// and compares whenever the DUT presents a response.
module tb_adder_arbiter;

    localparam int unsigned W = 32;
    localparam int unsigned N = 3;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_sum;
    logic [1:0]     rsp_id;
`ifdef ADDER_ARB_OVF_EN
    logic           rsp_ovf;
`endif

    adder_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
`ifdef ADDER_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic [1:0]   id;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   in_reset = 1'b1;
    int   ptr = 0;
    int   outstanding = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack3(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                             input logic [W-1:0] x2);
        return {x2, x1, x0};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'hFFFF_FFFF;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return W'($urandom);
        endcase
    endfunction

    // One clock cycle of stimulus plus the model's view of grant and result.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input logic rdy);
        int g;
        int idx;
        bit full;
        bit acc;
        logic [N-1:0] exp_ready;
        logic [W-1:0] opa, opb;
        longint unsigned us;
        longint sx;
        exp_t e;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rdy;
        #2;
        full = (outstanding > 0);
        acc  = !full || rdy;
        g    = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (g < 0 && v[idx]) g = idx;
        end
        exp_ready = '0;
        if (acc && g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (full && rdy) outstanding--;
        if (exp_ready != '0) begin
            opa   = a[g*W +: W];
            opb   = b[g*W +: W];
            us    = 64'(opa) + 64'(opb);
            e.sum = W'(us % 64'h1_0000_0000);
            e.id  = 2'(g);
            sx    = longint'($signed(opa)) + longint'($signed(opb));
            e.ovf = (sx > SMAX) || (sx < SMIN);
            q.push_back(e);
            ptr = (g + 1) % N;
            outstanding++;
        end
    endtask

    // One reset cycle; all buffered expectations are discarded.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_reset  = 1'b1;
        req_valid = N'($urandom_range(0, 7));
        req_a     = pack3(rnd_op(), rnd_op(), rnd_op());
        req_b     = pack3(rnd_op(), rnd_op(), rnd_op());
        rsp_ready = 1'($urandom_range(0, 1));
        #2;
        chk("req_ready_in_reset", 64'(req_ready), 64'd0);
        q.delete();
        ptr = 0;
        outstanding = 0;
        @(negedge clk);
        reset     = 1'b0;
        in_reset  = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        #2;
        chk("rsp_sum_after_reset", 64'(rsp_sum), 64'd0);
        chk("rsp_id_after_reset", 64'(rsp_id), 64'd0);
`ifdef ADDER_ARB_OVF_EN
        chk("rsp_ovf_after_reset", 64'(rsp_ovf), 64'd0);
`endif
    endtask

    // Monitor: response presence, content stability, and consumption.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!in_reset) begin
                chk("rsp_valid", 64'(rsp_valid), 64'(q.size() != 0));
                if (q.size() != 0) begin
                    chk("rsp_sum", 64'(rsp_sum), 64'(q[0].sum));
                    chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
`ifdef ADDER_ARB_OVF_EN
                    chk("rsp_ovf", 64'(rsp_ovf), 64'(q[0].ovf));
`endif
                    if (rsp_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] z;
        z = '0;
        do_reset();

        // Single request: 5 + 7 from requester 0.
        cycle(3'b001, pack3(32'd5, 0, 0), pack3(32'd7, 0, 0), 1'b0);
        cycle(3'b000, z, z, 1'b1);

        // Wrap and signed overflow corner cases.
        cycle(3'b001, pack3(32'hFFFF_FFFF, 0, 0), pack3(32'h0000_0002, 0, 0), 1'b1);
        cycle(3'b001, pack3(32'h7FFF_FFFF, 0, 0), pack3(32'h0000_0001, 0, 0), 1'b1);
        cycle(3'b000, z, z, 1'b1);

        // Round robin with all requesters held valid.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(3'b111, pack3(rnd_op(), rnd_op(), rnd_op()),
                  pack3(rnd_op(), rnd_op(), rnd_op()), 1'b1);
        end
        cycle(3'b000, z, z, 1'b1);

        // Backpressure: buffer full, consumer stalls for three cycles.
        do_reset();
        cycle(3'b001, pack3(32'd10, 0, 0), pack3(32'd20, 0, 0), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(3'b010, pack3(0, 32'd100, 0), pack3(0, 32'd23, 0), 1'b0);
        end
        cycle(3'b010, pack3(0, 32'd100, 0), pack3(0, 32'd23, 0), 1'b1);
        cycle(3'b000, z, z, 1'b1);

        // Reset while holding a stalled result, then grant resumes from 0.
        cycle(3'b100, pack3(0, 0, 32'd3), pack3(0, 0, 32'd4), 1'b0);
        do_reset();
        cycle(3'b110, pack3(0, 32'd1, 32'd2), pack3(0, 32'd3, 32'd4), 1'b1);
        cycle(3'b000, z, z, 1'b1);

        // Randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(N'($urandom_range(0, 7)), pack3(rnd_op(), rnd_op(), rnd_op()),
                      pack3(rnd_op(), rnd_op(), rnd_op()), 1'($urandom_range(0, 3) != 0));
            end
        end

        for (int i = 0; i < 3; i++) cycle(3'b000, z, z, 1'b1);
        #5;
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
